// File: rtl/csr_fifo_param.sv
// -----------------------------------------------------------------------------
// csr_fifo_param
// Parametrised FIFO that the CPU fills through CSR writes and a serial consumer
// (e.g. UART TX) drains with a next/have_next handshake. First-word
// fall-through: the head entry is visible on `data` whenever have_next=1.
//
// Ports
//   clk_i         clock
//   reset_i       synchronous active-high reset
//   csr_enable    CSR access valid this cycle
//   csr_addr      CSR address
//   csr_op        CSR operation (001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI)
//   rs1_zimm      immediate operand for the xxI operations
//   rs1_data      register operand
//   csr_data_out  read data of the addressed CSR (combinational)
//   next          consumer pop strobe, one pop per high cycle
//   data          head entry, valid while have_next=1 (0 when empty)
//   have_next     FIFO non-empty
//   almost_full   level >= AFULL_LVL
//   level         current occupancy, 0..DEPTH
//
// Status CSR layout: [0] empty, [1] full, [2] almost_full, [3] overflow,
// [4] underflow, [8+:LVL_W] level. Writing 1 to bit 3/4 clears the matching
// sticky flag; writing 1 to bit 31 (register ops only) flushes the FIFO.
// -----------------------------------------------------------------------------
module csr_fifo_param #(
  parameter int          DATA_W    = 8,
  parameter int          DEPTH     = 16,
  parameter int          AFULL_LVL = 12,
  parameter logic [11:0] DATA_ADDR = 12'h051,
  parameter logic [11:0] STAT_ADDR = 12'h052,
  localparam int         LVL_W     = $clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              csr_enable,
  input  logic [11:0]       csr_addr,
  input  logic [2:0]        csr_op,
  input  logic [4:0]        rs1_zimm,
  input  logic [31:0]       rs1_data,
  output logic [31:0]       csr_data_out,
  input  logic              next,
  output logic [DATA_W-1:0] data,
  output logic              have_next,
  output logic              almost_full,
  output logic [LVL_W-1:0]  level
);

  localparam int AW = LVL_W - 1;

  localparam logic [2:0] OP_RW  = 3'b001;
  localparam logic [2:0] OP_RS  = 3'b010;
  localparam logic [2:0] OP_RWI = 3'b101;
  localparam logic [2:0] OP_RSI = 3'b110;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [LVL_W-1:0]  wr_ptr_r;
  logic [LVL_W-1:0]  rd_ptr_r;
  logic              overflow_r;
  logic              underflow_r;

  logic [31:0]       operand_s;
  logic              data_hit_s;
  logic              stat_hit_s;
  logic              push_req_s;
  logic              stat_wr_s;
  logic              flush_s;
  logic              empty_s;
  logic              full_s;
  logic [LVL_W-1:0]  level_s;
  logic              pop_s;
  logic              push_s;
  logic              ovf_set_s;
  logic              udf_set_s;
  logic [31:0]       stat_word_s;
  logic              unused_operand_s;

  // Decode the CSR access and derive FIFO control strobes.
  always_comb begin
    operand_s  = csr_op[2] ? {27'd0, rs1_zimm} : rs1_data;
    data_hit_s = csr_enable && (csr_addr == DATA_ADDR);
    stat_hit_s = csr_enable && (csr_addr == STAT_ADDR);
    case (csr_op)
      OP_RW, OP_RWI: push_req_s = data_hit_s;
      default:       push_req_s = 1'b0;
    endcase
    case (csr_op)
      OP_RW, OP_RS, OP_RWI, OP_RSI: stat_wr_s = stat_hit_s;
      default:                      stat_wr_s = 1'b0;
    endcase
    // Immediate operands are only 5 bits wide, so they can never reach bit 31.
    flush_s   = stat_wr_s && !csr_op[2] && operand_s[31];
    empty_s   = (wr_ptr_r == rd_ptr_r);
    full_s    = (wr_ptr_r[LVL_W-1] != rd_ptr_r[LVL_W-1]) &&
                (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    level_s   = wr_ptr_r - rd_ptr_r;
    pop_s     = next && !empty_s;
    // At full a simultaneous pop frees the slot the push needs.
    push_s    = push_req_s && (!full_s || pop_s);
    ovf_set_s = push_req_s && full_s && !pop_s;
    udf_set_s = next && empty_s;
  end

  // Only the CSR-visible operand bits are consumed; fold the rest away.
  assign unused_operand_s = ^operand_s;

  // Build the status word and select the CSR read data.
  always_comb begin
    stat_word_s              = 32'd0;
    stat_word_s[0]           = empty_s;
    stat_word_s[1]           = full_s;
    stat_word_s[2]           = almost_full;
    stat_word_s[3]           = overflow_r;
    stat_word_s[4]           = underflow_r;
    stat_word_s[8 +: LVL_W]  = level_s;
    if (stat_hit_s) begin
      csr_data_out = stat_word_s;
    end else begin
      csr_data_out = 32'd0;
    end
  end

  // Storage array; deliberately not reset, only the pointers are.
  always_ff @(posedge clk_i) begin
    if (push_s && !flush_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= operand_s[DATA_W-1:0];
    end
  end

  // Read/write pointers with natural wrap; flush overrides any push/pop.
  always_ff @(posedge clk_i) begin
    if (reset_i || flush_s) begin
      wr_ptr_r <= {LVL_W{1'b0}};
      rd_ptr_r <= {LVL_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + LVL_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + LVL_W'(1);
      end
    end
  end

  // Sticky error flags: a new event beats a same-cycle W1C clear.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end else if (stat_wr_s && operand_s[3]) begin
        overflow_r <= 1'b0;
      end
      if (udf_set_s) begin
        underflow_r <= 1'b1;
      end else if (stat_wr_s && operand_s[4]) begin
        underflow_r <= 1'b0;
      end
    end
  end

  // Consumer-facing outputs, all derived from registered state.
  always_comb begin
    have_next   = !empty_s;
    level       = level_s;
    almost_full = (level_s >= LVL_W'(AFULL_LVL));
    if (empty_s) begin
      data = {DATA_W{1'b0}};
    end else begin
      data = mem_r[rd_ptr_r[AW-1:0]];
    end
  end

endmodule

// File: tb/tb_csr_fifo_param.sv
module tb_csr_fifo_param;

  localparam logic [11:0] DATA_ADDR = 12'h051;
  localparam logic [11:0] STAT_ADDR = 12'h052;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic        csr_enable = 1'b0;
  logic [11:0] csr_addr = 12'd0;
  logic [2:0]  csr_op = 3'd0;
  logic [4:0]  rs1_zimm = 5'd0;
  logic [31:0] rs1_data = 32'd0;
  logic [31:0] csr_data_out;
  logic        next = 1'b0;
  logic [7:0]  data;
  logic        have_next;
  logic        almost_full;
  logic [4:0]  level;

  int errors = 0;
  int checks = 0;

  csr_fifo_param dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .csr_enable   (csr_enable),
    .csr_addr     (csr_addr),
    .csr_op       (csr_op),
    .rs1_zimm     (rs1_zimm),
    .rs1_data     (rs1_data),
    .csr_data_out (csr_data_out),
    .next         (next),
    .data         (data),
    .have_next    (have_next),
    .almost_full  (almost_full),
    .level        (level)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [2:0] op,
                           input logic [31:0] val, input logic [4:0] zimm);
    csr_enable = 1'b1;
    csr_addr   = addr;
    csr_op     = op;
    rs1_data   = val;
    rs1_zimm   = zimm;
    tick();
    csr_enable = 1'b0;
    csr_op     = 3'd0;
    rs1_data   = 32'd0;
    rs1_zimm   = 5'd0;
  endtask

  task automatic push(input logic [31:0] val);
    csr_write(DATA_ADDR, 3'b001, val, 5'd0);
  endtask

  task automatic pop();
    next = 1'b1;
    tick();
    next = 1'b0;
  endtask

  task automatic read_stat(output logic [31:0] v);
    csr_enable = 1'b1;
    csr_addr   = STAT_ADDR;
    csr_op     = 3'b010;
    rs1_data   = 32'd0;
    #1;
    v = csr_data_out;
    csr_enable = 1'b0;
    csr_op     = 3'd0;
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] s;
    reset_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
    read_stat(s);
    checks++; if (have_next !== 1'b0) begin errors++; $display("FAIL reset_have_next got=%b exp=0", have_next); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_afull got=%b exp=0", almost_full); end
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", data); end
    checks++; if (s !== 32'h0000_0001) begin errors++; $display("FAIL reset_stat got=%h exp=00000001", s); end
  endtask

  task automatic test_order();
    logic [7:0] exp [8];
    exp = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78};
    for (int i = 0; i < 8; i++) push({24'd0, exp[i]});
    checks++; if (level !== 5'd8) begin errors++; $display("FAIL order_level8 got=%0d exp=8", level); end
    checks++; if (data !== 8'hDE) begin errors++; $display("FAIL order_head got=%h exp=de", data); end
    for (int i = 0; i < 8; i++) begin
      pop();
      checks++; if (level !== 5'(7 - i)) begin errors++; $display("FAIL order_level i=%0d got=%0d exp=%0d", i, level, 7 - i); end
      if (i < 7) begin
        checks++; if (data !== exp[i+1]) begin errors++; $display("FAIL order_data i=%0d got=%h exp=%h", i, data, exp[i+1]); end
      end else begin
        checks++; if (have_next !== 1'b0) begin errors++; $display("FAIL order_empty got=%b exp=0", have_next); end
      end
      tick();
      tick();
    end
  endtask

  task automatic test_overflow();
    logic [31:0] s;
    for (int i = 0; i < 17; i++) begin
      push(32'(i));
      if (i == 10 || i == 11) begin
        checks++; if (almost_full !== (i == 11)) begin errors++; $display("FAIL ovf_afull_edge n=%0d got=%b", i + 1, almost_full); end
      end
    end
    read_stat(s);
    checks++; if (s !== 32'h0000_100E) begin errors++; $display("FAIL ovf_stat got=%h exp=0000100e", s); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (data !== 8'(i)) begin errors++; $display("FAIL ovf_pop i=%0d got=%h exp=%h", i, data, 8'(i)); end
      pop();
    end
    csr_write(STAT_ADDR, 3'b001, 32'h0000_0008, 5'd0);
    read_stat(s);
    checks++; if (s !== 32'h0000_0001) begin errors++; $display("FAIL ovf_w1c got=%h exp=00000001", s); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] s;
    for (int i = 0; i < 16; i++) push(32'h40 + 32'(i));
    csr_enable = 1'b1; csr_addr = DATA_ADDR; csr_op = 3'b001; rs1_data = 32'hA5; next = 1'b1;
    tick();
    csr_enable = 1'b0; csr_op = 3'd0; rs1_data = 32'd0; next = 1'b0;
    read_stat(s);
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL fpp_level got=%0d exp=16", level); end
    checks++; if (s !== 32'h0000_1006) begin errors++; $display("FAIL fpp_stat got=%h exp=00001006", s); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (data !== ((i == 15) ? 8'hA5 : 8'h41 + 8'(i))) begin
        errors++; $display("FAIL fpp_pop i=%0d got=%h", i, data);
      end
      pop();
    end
  endtask

  task automatic test_underflow();
    logic [31:0] s;
    pop();
    read_stat(s);
    checks++; if (s !== 32'h0000_0011) begin errors++; $display("FAIL udf_stat got=%h exp=00000011", s); end
    checks++; if (have_next !== 1'b0 || level !== 5'd0) begin errors++; $display("FAIL udf_state got=%b/%0d exp=0/0", have_next, level); end
    // Clear and new underflow in the same cycle: the new event must win.
    csr_enable = 1'b1; csr_addr = STAT_ADDR; csr_op = 3'b001; rs1_data = 32'h10; next = 1'b1;
    tick();
    csr_enable = 1'b0; csr_op = 3'd0; rs1_data = 32'd0; next = 1'b0;
    read_stat(s);
    checks++; if (s !== 32'h0000_0011) begin errors++; $display("FAIL udf_set_wins got=%h exp=00000011", s); end
    csr_write(STAT_ADDR, 3'b001, 32'h0000_0010, 5'd0);
    read_stat(s);
    checks++; if (s !== 32'h0000_0001) begin errors++; $display("FAIL udf_w1c got=%h exp=00000001", s); end
  endtask

  task automatic test_csr_ops();
    csr_write(DATA_ADDR, 3'b101, 32'hFFFF_FF00, 5'h1F);
    checks++; if (data !== 8'h1F || level !== 5'd1) begin errors++; $display("FAIL rwi_push got=%h/%0d exp=1f/1", data, level); end
    csr_write(DATA_ADDR, 3'b010, 32'h0000_00FF, 5'd0);
    checks++; if (data !== 8'h1F || level !== 5'd1) begin errors++; $display("FAIL rs_nopush got=%h/%0d exp=1f/1", data, level); end
    csr_enable = 1'b1; csr_addr = DATA_ADDR; csr_op = 3'b010; #1;
    checks++; if (csr_data_out !== 32'd0) begin errors++; $display("FAIL data_csr_read got=%h exp=0", csr_data_out); end
    csr_addr = 12'h053; #1;
    checks++; if (csr_data_out !== 32'd0) begin errors++; $display("FAIL other_addr_read got=%h exp=0", csr_data_out); end
    csr_enable = 1'b0; csr_op = 3'd0; #1;
    // RC on the status register must not flush even with bit 31 set.
    csr_write(STAT_ADDR, 3'b011, 32'h8000_0000, 5'd0);
    checks++; if (level !== 5'd1) begin errors++; $display("FAIL rc_noflush got=%0d exp=1", level); end
  endtask

  task automatic test_flush_reset();
    logic [31:0] s;
    pop();
    pop();
    for (int i = 0; i < 5; i++) push(32'h60 + 32'(i));
    checks++; if (level !== 5'd5) begin errors++; $display("FAIL flush_pre got=%0d exp=5", level); end
    csr_enable = 1'b1; csr_addr = STAT_ADDR; csr_op = 3'b001; rs1_data = 32'h8000_0000; next = 1'b1;
    tick();
    csr_enable = 1'b0; csr_op = 3'd0; rs1_data = 32'd0; next = 1'b0;
    read_stat(s);
    checks++; if (level !== 5'd0 || have_next !== 1'b0) begin errors++; $display("FAIL flush got=%0d/%b exp=0/0", level, have_next); end
    checks++; if (s !== 32'h0000_0011) begin errors++; $display("FAIL flush_sticky got=%h exp=00000011", s); end
    for (int i = 0; i < 3; i++) push(32'h70 + 32'(i));
    checks++; if (level !== 5'd3 || data !== 8'h70) begin errors++; $display("FAIL refill got=%0d/%h exp=3/70", level, data); end
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    read_stat(s);
    checks++; if (level !== 5'd0 || have_next !== 1'b0) begin errors++; $display("FAIL midreset got=%0d/%b exp=0/0", level, have_next); end
    checks++; if (s !== 32'h0000_0001) begin errors++; $display("FAIL midreset_stat got=%h exp=00000001", s); end
  endtask

  initial begin
    #1;
    test_reset();
    test_order();
    test_overflow();
    test_full_push_pop();
    test_underflow();
    test_csr_ops();
    test_flush_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
